// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (port 0) vs buffered muldiv results (port 1),
// with a long-latency scoreboard. Define RF_WB_ARB_PERF_EN to add stall/conflict performance counters.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic [4:0]  wb0_addr,
  input  logic [63:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic [4:0]  wb1_addr,
  input  logic [63:0] wb1_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        rf_wvalid,
  output logic [4:0]  rf_wa,
  output logic [63:0] rf_wd,
  output logic [31:0] busy_mask
`ifdef RF_WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_conflict_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]    addr_mem_q [DEPTH];
  logic [4:0]    addr_mem_d [DEPTH];
  logic [63:0]   data_mem_q [DEPTH];
  logic [63:0]   data_mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    wait_q, wait_d;
  logic          init_q, init_d;
  logic          rf_wvalid_q, rf_wvalid_d;
  logic [4:0]    rf_wa_q, rf_wa_d;
  logic [63:0]   rf_wd_q, rf_wd_d;
  logic [31:0]   busy_q, busy_d;

  logic          fifo_full, fifo_nonempty, push, starve, grant0, grant_fifo;
  logic [4:0]    head_addr;
  logic [63:0]   head_data;

  always_comb begin
    fifo_full     = (count_q == CW'(DEPTH));
    fifo_nonempty = (count_q != '0);
    // init_q holds off intake until the first edge after reset release
    wb1_ready     = init_q && !fifo_full;
    push          = wb1_valid && wb1_ready;
    starve        = fifo_nonempty && (wait_q == 4'(MAX_WAIT));
    grant_fifo    = starve || (!wb0_valid && fifo_nonempty);
    grant0        = !starve && wb0_valid;
    wb0_ready     = !starve;
    head_addr     = addr_mem_q[rd_ptr_q];
    head_data     = data_mem_q[rd_ptr_q];
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    init_d     = 1'b1;
    if (push) begin
      addr_mem_d[wr_ptr_q] = wb1_addr;
      data_mem_d[wr_ptr_q] = wb1_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (grant_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(grant_fifo);

    if (!fifo_nonempty || grant_fifo)  wait_d = '0;
    else if (wait_q != 4'(MAX_WAIT))   wait_d = wait_q + 4'd1;
    else                               wait_d = wait_q;

    rf_wvalid_d = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    if (grant0) begin
      rf_wvalid_d = (wb0_addr != 5'd0);
      rf_wa_d     = wb0_addr;
      rf_wd_d     = wb0_data;
    end else if (grant_fifo) begin
      rf_wvalid_d = (head_addr != 5'd0);
      rf_wa_d     = head_addr;
      rf_wd_d     = head_data;
    end

    // set after clear: a newer issue to the same register stays outstanding
    busy_d = busy_q;
    if (grant_fifo) busy_d[head_addr] = 1'b0;
    if (issue_valid && (issue_addr != 5'd0)) busy_d[issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      init_q      <= 1'b0;
      rf_wvalid_q <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      init_q      <= init_d;
      rf_wvalid_q <= rf_wvalid_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      busy_q      <= busy_d;
    end
  end

  assign rf_wvalid = rf_wvalid_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;
  assign busy_mask = busy_q;

`ifdef RF_WB_ARB_PERF_EN
  logic [31:0] stall_q, stall_d, conflict_q, conflict_d;

  always_comb begin
    stall_d    = stall_q + 32'(wb0_valid && !wb0_ready);
    conflict_d = conflict_q + 32'(wb0_valid && fifo_nonempty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q    <= '0;
      conflict_q <= '0;
    end else begin
      stall_q    <= stall_d;
      conflict_q <= conflict_d;
    end
  end

  assign perf_stall_cnt    = stall_q;
  assign perf_conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based reference model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb0_ready;
  logic [4:0]  wb0_addr;
  logic [63:0] wb0_data;
  logic        wb1_valid, wb1_ready;
  logic [4:0]  wb1_addr;
  logic [63:0] wb1_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        rf_wvalid;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [31:0] busy_mask;
`ifdef RF_WB_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_conflict_cnt;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rf_wvalid(rf_wvalid), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy_mask(busy_mask)
`ifdef RF_WB_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  // reference model state
  ent_t        q[$];
  int          wcnt;
  bit          init;
  logic [31:0] m_busy;
  logic        m_wv;
  logic [4:0]  m_wa;
  logic [63:0] m_wd;
  logic [31:0] m_stall, m_conf;
  bit          last_push;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wcnt = 0; init = 0; m_busy = '0;
    m_wv = 0; m_wa = '0; m_wd = '0;
    m_stall = '0; m_conf = '0;
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb0_addr = '0; wb0_data = '0;
    wb1_valid = 0; wb1_addr = '0; wb1_data = '0;
    issue_valid = 0; issue_addr = '0;
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, returns at next posedge+1.
  task automatic cycle();
    bit ne, st, gf, g0, pushed;
    ent_t h;
    logic [31:0] nb;
    logic        nwv;
    logic [4:0]  nwa;
    logic [63:0] nwd;
    int          nw;
    #3;
    ne = (q.size() != 0);
    st = ne && (wcnt == MAX_WAIT);
    check_eq("wb0_ready", wb0_ready, !st);
    check_eq("wb1_ready", wb1_ready, init && (q.size() < DEPTH));
    check_eq("rf_wvalid", rf_wvalid, m_wv);
    check_eq("rf_wa", rf_wa, m_wa);
    check_eq("rf_wd", rf_wd, m_wd);
    check_eq("busy_mask", busy_mask, m_busy);
`ifdef RF_WB_ARB_PERF_EN
    check_eq("perf_stall", perf_stall_cnt, m_stall);
    check_eq("perf_conflict", perf_conflict_cnt, m_conf);
`endif
    gf = st || (!wb0_valid && ne);
    g0 = wb0_valid && !st;
    pushed = wb1_valid && init && (q.size() < DEPTH);
    nb = m_busy; nwv = 0; nwa = m_wa; nwd = m_wd;
    if (g0) begin
      nwv = (wb0_addr != 0); nwa = wb0_addr; nwd = wb0_data;
    end else if (gf) begin
      h = q[0];
      nwv = (h.a != 0); nwa = h.a; nwd = h.d;
      nb[h.a] = 1'b0;
    end
    if (issue_valid && issue_addr != 0) nb[issue_addr] = 1'b1;
    nb[0] = 1'b0;
    nw = (!ne || gf) ? 0 : ((wcnt + 1 > MAX_WAIT) ? MAX_WAIT : wcnt + 1);
    if (wb0_valid && st) m_stall = m_stall + 1;
    if (wb0_valid && ne) m_conf  = m_conf + 1;
    if (gf) void'(q.pop_front());
    if (pushed) q.push_back('{a: wb1_addr, d: wb1_data});
    @(posedge clk); #1;
    m_busy = nb; m_wv = nwv; m_wa = nwa; m_wd = nwd; wcnt = nw; init = 1;
    last_push = pushed;
  endtask

  task automatic do_reset();
    #3;
    reset = 0;
    #1;
    check_eq("rst_rf_wvalid", rf_wvalid, 0);
    check_eq("rst_busy_mask", busy_mask, 0);
    check_eq("rst_rf_wa", rf_wa, 0);
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
    reset = 1;
  endtask

  logic [4:0] order[$];

  initial begin
    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();
    cycle();
    check_eq("wb1_ready_after_rst", wb1_ready, 1);

    // port 0 alone
    wb0_valid = 1; wb0_addr = 5; wb0_data = 64'hDEAD_BEEF;
    cycle();
    idle_inputs();
    check_eq("p0_wvalid", rf_wvalid, 1);
    check_eq("p0_wa", rf_wa, 5);
    check_eq("p0_wd", rf_wd, 64'hDEAD_BEEF);
    cycle();
    check_eq("p0_wvalid_drop", rf_wvalid, 0);

    // scoreboard
    issue_valid = 1; issue_addr = 7;
    cycle();
    idle_inputs();
    check_eq("sb_set7", busy_mask[7], 1);
    wb1_valid = 1; wb1_addr = 7; wb1_data = 64'h42;
    cycle();
    idle_inputs();
    cycle();
    check_eq("sb_wa7", rf_wa, 7);
    check_eq("sb_wd42", rf_wd, 64'h42);
    check_eq("sb_clr7", busy_mask[7], 0);

    // starvation
    wb0_valid = 1; wb0_addr = 1; wb0_data = 64'h11;
    wb1_valid = 1; wb1_addr = 3; wb1_data = 64'h33;
    cycle();
    wb1_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("starve_p0_grant", rf_wa, 1);
    end
    cycle();
    check_eq("starve_x3_wa", rf_wa, 3);
    check_eq("starve_x3_wd", rf_wd, 64'h33);
    cycle();
    check_eq("starve_p0_resume", rf_wa, 1);
    idle_inputs();
    cycle();

    // FIFO full and ordering
    order.delete();
    wb0_valid = 1; wb0_addr = 1; wb0_data = 64'h1;
    wb1_valid = 1; wb1_addr = 10; wb1_data = 64'hA;
    cycle();
    wb1_addr = 11; wb1_data = 64'hB;
    cycle();
    check_eq("full_wb1_ready", wb1_ready, 0);
    wb1_addr = 12; wb1_data = 64'hC;
    last_push = 0;
    for (int i = 0; i < 20 && !last_push; i++) begin
      cycle();
      if (rf_wvalid && rf_wa >= 10) order.push_back(rf_wa);
    end
    check_eq("full_x12_accepted", last_push, 1);
    wb1_valid = 0; wb0_valid = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (rf_wvalid && rf_wa >= 10) order.push_back(rf_wa);
    end
    check_eq("order_len", order.size(), 3);
    if (order.size() == 3) begin
      check_eq("order0", order[0], 10);
      check_eq("order1", order[1], 11);
      check_eq("order2", order[2], 12);
    end

    // x0 write is consumed silently
    wb0_valid = 1; wb0_addr = 0; wb0_data = 64'h99;
    cycle();
    idle_inputs();
    check_eq("x0_wvalid", rf_wvalid, 0);

    // same-bit set/clear collision
    issue_valid = 1; issue_addr = 9;
    cycle();
    idle_inputs();
    wb1_valid = 1; wb1_addr = 9; wb1_data = 64'h9;
    cycle();
    wb1_valid = 0;
    issue_valid = 1; issue_addr = 9;
    cycle();
    idle_inputs();
    check_eq("collide_wa9", rf_wa, 9);
    check_eq("collide_bit9", busy_mask[9], 1);
    cycle();

    // reset mid-operation
    wb0_valid = 1; wb0_addr = 2; wb0_data = 64'h2;
    issue_valid = 1; issue_addr = 4;
    wb1_valid = 1; wb1_addr = 4; wb1_data = 64'h4;
    cycle();
    issue_addr = 5; wb1_addr = 5; wb1_data = 64'h5;
    cycle();
    idle_inputs();
    check_eq("pre_rst_busy", busy_mask, 32'h0000_0030 | m_busy);
    do_reset();
    cycle();
    check_eq("post_rst_wb1_ready", wb1_ready, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      wb0_valid   = ($urandom_range(0, 99) < 50);
      wb0_addr    = 5'($urandom_range(0, 31));
      wb0_data    = {$urandom, $urandom};
      wb1_valid   = ($urandom_range(0, 99) < 40);
      wb1_addr    = 5'($urandom_range(0, 31));
      wb1_data    = {$urandom, $urandom};
      issue_valid = ($urandom_range(0, 99) < 30);
      issue_addr  = 5'($urandom_range(0, 31));
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
